siso_shift_hold_p: RTL and testbench

- Parametrised serial-in/serial-out shift register with a built-in shift/hold duty pattern.
- Shifts for SHIFT_CYC enabled cycles, then freezes for HOLD_CYC enabled cycles, and repeats.
- Generalises the fixed 1-bit "shift 2 / hold 2" SISO to multi-bit lanes, configurable depth and duty, clock enable, parallel load and parallel readout.
- Used as a timed serialiser/delay line in front of slow consumers.

---
 rtl/siso_pkg.sv | 18 +
 rtl/siso_shift_hold_p_seq.sv | 69 ++++++
 rtl/siso_shift_hold_p.sv | 56 +++++
 tb/tb_siso_shift_hold_p.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/siso_pkg.sv
// Shared types and helpers for the shift/hold serial-in serial-out register.
package siso_pkg;

    typedef enum logic {
        PH_SHIFT = 1'b0,
        PH_HOLD  = 1'b1
    } phase_t;

    // Counter width wide enough for the longer of the two phases (minimum 1 bit).
    function automatic int clog2_max(input int shift_cyc, input int hold_cyc);
        int m;
        m = 2;
        if (shift_cyc > m) m = shift_cyc;
        if (hold_cyc > m) m = hold_cyc;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/siso_shift_hold_p_seq.sv
// Duty-pattern sequencer: the SHIFT/HOLD phase FSM and its cycle counter.
import siso_pkg::*;

module shift_hold_seq #(
    parameter int SHIFT_CYC = 2,
    parameter int HOLD_CYC  = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  logic   load,
    output phase_t phase,
    output logic   shift_tick
);

    localparam int CNT_W = clog2_max(SHIFT_CYC, HOLD_CYC);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_CYC - 1);
    // With HOLD_CYC=0 the hold phase is never entered, so this value is unused.
    localparam logic [CNT_W-1:0] HOLD_LAST  = (HOLD_CYC > 0) ? CNT_W'(HOLD_CYC - 1) : '0;

    phase_t           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_SHIFT;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        if (load) begin
            phase_d = PH_SHIFT;
            cnt_d   = '0;
        end else if (en) begin
            case (phase_q)
                PH_SHIFT: begin
                    if (cnt_q == SHIFT_LAST) begin
                        cnt_d   = '0;
                        phase_d = (HOLD_CYC > 0) ? PH_HOLD : PH_SHIFT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PH_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d   = '0;
                        phase_d = PH_SHIFT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    phase_d = PH_SHIFT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign phase      = phase_q;
    assign shift_tick = en && !load && (phase_q == PH_SHIFT);

endmodule

// File: rtl/siso_shift_hold_p.sv
// Multi-lane SISO shift register that alternates SHIFT_CYC shifting and HOLD_CYC frozen enabled cycles.
import siso_pkg::*;

module siso_shift_hold_p #(
    parameter int WIDTH     = 1,
    parameter int DEPTH     = 4,
    parameter int SHIFT_CYC = 2,
    parameter int HOLD_CYC  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   load,
    input  logic [DEPTH*WIDTH-1:0] pdin,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [DEPTH*WIDTH-1:0] pout,
    output logic                   shifting
);

    phase_t           phase;
    logic             shift_tick;
    logic [WIDTH-1:0] stage_q [DEPTH];

    shift_hold_seq #(
        .SHIFT_CYC (SHIFT_CYC),
        .HOLD_CYC  (HOLD_CYC)
    ) u_seq (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .phase      (phase),
        .shift_tick (shift_tick)
    );

    // shift_tick already excludes load, so load wins over a shift on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= pdin[i*WIDTH +: WIDTH];
        end else if (shift_tick) begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_pout
        assign pout[g*WIDTH +: WIDTH] = stage_q[g];
    end

    assign dout     = stage_q[DEPTH-1];
    assign shifting = (phase == PH_SHIFT);

endmodule

// File: tb/tb_siso_shift_hold_p.sv
// Directed bench for siso_shift_hold_p over default, wide/no-hold and 1:3 duty configurations.
module tb_siso_shift_hold_p;

    int tests  = 0;
    int failed = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default configuration: WIDTH=1 DEPTH=4 SHIFT=2 HOLD=2
    logic       d_rst = 1'b0, d_en = 1'b0, d_load = 1'b0;
    logic [3:0] d_pdin = '0;
    logic       d_din = 1'b0;
    logic       d_dout;
    logic [3:0] d_pout;
    logic       d_shifting;

    siso_shift_hold_p u_def (
        .clk(clk), .rst(d_rst), .en(d_en), .load(d_load), .pdin(d_pdin),
        .din(d_din), .dout(d_dout), .pout(d_pout), .shifting(d_shifting)
    );

    // wide lanes, no hold phase
    logic        w_rst = 1'b0, w_en = 1'b0, w_load = 1'b0;
    logic [23:0] w_pdin = '0;
    logic [7:0]  w_din = '0;
    logic [7:0]  w_dout;
    logic [23:0] w_pout;
    logic        w_shifting;

    siso_shift_hold_p #(.WIDTH(8), .DEPTH(3), .SHIFT_CYC(2), .HOLD_CYC(0)) u_wide (
        .clk(clk), .rst(w_rst), .en(w_en), .load(w_load), .pdin(w_pdin),
        .din(w_din), .dout(w_dout), .pout(w_pout), .shifting(w_shifting)
    );

    // one shift then three holds
    logic       u_rst = 1'b0, u_en = 1'b0, u_load = 1'b0;
    logic [3:0] u_pdin = '0;
    logic       u_din = 1'b0;
    logic       u_dout;
    logic [3:0] u_pout;
    logic       u_shifting;

    siso_shift_hold_p #(.WIDTH(1), .DEPTH(4), .SHIFT_CYC(1), .HOLD_CYC(3)) u_duty (
        .clk(clk), .rst(u_rst), .en(u_en), .load(u_load), .pdin(u_pdin),
        .din(u_din), .dout(u_dout), .pout(u_pout), .shifting(u_shifting)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are applied, then one rising edge, then outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_def(input logic rst, input logic en, input logic load,
                           input logic [3:0] pdin, input logic din);
        d_rst = rst; d_en = en; d_load = load; d_pdin = pdin; d_din = din;
        tick();
    endtask

    initial begin
        #2;
        // reset all instances together
        d_rst = 1'b1; w_rst = 1'b1; u_rst = 1'b1;
        tick();
        d_rst = 1'b0; w_rst = 1'b0; u_rst = 1'b0;
        check("def_reset_pout", 32'(d_pout), 32'h0);
        check("def_reset_dout", 32'(d_dout), 32'h0);
        check("def_reset_shifting", 32'(d_shifting), 32'h1);
        check("wide_reset_pout", 32'(w_pout), 32'h0);

        // shift 2 / hold 2 pattern, din e1..e6 = 1,0,1,1,1,1
        drv_def(0, 1, 0, 4'h0, 1);
        check("t1_e1_pout", 32'(d_pout), 32'h1);
        check("t1_e1_shifting", 32'(d_shifting), 32'h1);
        drv_def(0, 1, 0, 4'h0, 0);
        check("t1_e2_pout", 32'(d_pout), 32'h2);
        check("t1_e2_shifting", 32'(d_shifting), 32'h0);
        drv_def(0, 1, 0, 4'h0, 1);
        check("t1_e3_pout", 32'(d_pout), 32'h2);
        check("t1_e3_shifting", 32'(d_shifting), 32'h0);
        drv_def(0, 1, 0, 4'h0, 1);
        check("t1_e4_pout", 32'(d_pout), 32'h2);
        check("t1_e4_shifting", 32'(d_shifting), 32'h1);
        drv_def(0, 1, 0, 4'h0, 1);
        check("t1_e5_pout", 32'(d_pout), 32'h5);
        drv_def(0, 1, 0, 4'h0, 1);
        check("t1_e6_pout", 32'(d_pout), 32'hB);
        check("t1_e6_dout", 32'(d_dout), 32'h1);

        // reset and load on the same edge: reset wins
        drv_def(1, 1, 1, 4'hF, 1);
        check("t4_pout", 32'(d_pout), 32'h0);
        check("t4_dout", 32'(d_dout), 32'h0);
        check("t4_shifting", 32'(d_shifting), 32'h1);
        drv_def(0, 1, 0, 4'h0, 1);
        check("t4_s1_pout", 32'(d_pout), 32'h1);
        check("t4_s1_shifting", 32'(d_shifting), 32'h1);
        drv_def(0, 1, 0, 4'h0, 1);
        check("t4_s2_pout", 32'(d_pout), 32'h3);
        check("t4_s2_shifting", 32'(d_shifting), 32'h0);

        // load during hold restarts the duty pattern
        drv_def(1, 0, 0, 4'h0, 0);
        drv_def(0, 1, 0, 4'h0, 1);
        drv_def(0, 1, 0, 4'h0, 0);
        drv_def(0, 1, 0, 4'h0, 1);
        check("t2_hold_pout", 32'(d_pout), 32'h2);
        check("t2_hold_shifting", 32'(d_shifting), 32'h0);
        drv_def(0, 1, 1, 4'hC, 1);
        check("t2_load_pout", 32'(d_pout), 32'hC);
        check("t2_load_shifting", 32'(d_shifting), 32'h1);
        drv_def(0, 1, 0, 4'h0, 1);
        check("t2_s1_pout", 32'(d_pout), 32'h9);
        drv_def(0, 1, 0, 4'h0, 1);
        check("t2_s2_pout", 32'(d_pout), 32'h3);
        check("t2_s2_shifting", 32'(d_shifting), 32'h0);
        drv_def(0, 1, 0, 4'h0, 0);
        check("t2_hold_after_pout", 32'(d_pout), 32'h3);

        // en=0 freezes everything at cnt=1
        drv_def(1, 0, 0, 4'h0, 0);
        drv_def(0, 1, 0, 4'h0, 1);
        for (int i = 0; i < 3; i++) begin
            drv_def(0, 0, 0, 4'h0, i[0]);
            check("t3_frozen_pout", 32'(d_pout), 32'h1);
            check("t3_frozen_shifting", 32'(d_shifting), 32'h1);
        end
        drv_def(0, 1, 0, 4'h0, 0);
        check("t3_resume_pout", 32'(d_pout), 32'h2);
        check("t3_resume_shifting", 32'(d_shifting), 32'h0);

        // 8-bit lanes, depth 3, no hold
        w_en = 1'b1;
        w_din = 8'hA5; tick();
        check("t5_e1_dout", 32'(w_dout), 32'h0);
        check("t5_e1_shifting", 32'(w_shifting), 32'h1);
        w_din = 8'h3C; tick();
        check("t5_e2_shifting", 32'(w_shifting), 32'h1);
        w_din = 8'hFF; tick();
        check("t5_e3_shifting", 32'(w_shifting), 32'h1);
        check("t5_e3_dout", 32'(w_dout), 32'hA5);
        check("t5_e3_pout", 32'(w_pout), 32'hA53CFF);
        w_en = 1'b0;

        // 1:3 duty: shifting 1,0,0,0 and one shift every 4 edges
        check("t6_reset_shifting", 32'(u_shifting), 32'h1);
        u_en = 1'b1; u_din = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check("t6_shifting", 32'(u_shifting), (e % 4 == 0) ? 32'h1 : 32'h0);
            check("t6_pout", 32'(u_pout), (e <= 4) ? 32'h1 : 32'h3);
        end
        u_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
